// File: rtl/vdu_mem_arbiter.sv
// Display-RAM arbiter: the VDU scanline fetcher has absolute priority, and the CPU waits behind it through a req/ack FSM.
// Optional VDU_ARB_WBUF_EN adds a one-entry posted write buffer so CPU writes are not stalled by VDU bursts.
module vdu_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              i_clk_sys,
    input  logic              i_rst,
    input  logic              i_vdu_read_en,
    input  logic [ADDR_W-1:0] i_vdu_read_addr,
    output logic [DATA_W-1:0] o_vdu_data,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    // state   | meaning
    // IDLE    | waiting for i_cpu_req; request fields are latched on exit
    // PEND    | latched access waiting for a free RAM slot
    // RD_DATA | RAM read data returning; captured into o_cpu_rdata
    // ACK     | one-cycle o_cpu_ack pulse
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_RD_DATA, S_ACK} state_t;

    state_t              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic                ack_q;
    logic                vdu_pend_q;
    logic [DATA_W-1:0]   vdu_data_q;

    logic                drain;
    logic                wb_load;
    logic                wb_busy;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic                cpu_issue;

`ifdef VDU_ARB_WBUF_EN
    logic                wb_valid_q;
    logic [ADDR_W-1:0]   wb_addr_q;
    logic [DATA_W-1:0]   wb_data_q;

    // A pending write only goes into the buffer when the VDU holds the port; a free slot writes straight through.
    assign wb_load = (state_q == S_PEND) && we_q && !wb_valid_q && i_vdu_read_en && !i_rst;
    assign drain   = wb_valid_q && !i_vdu_read_en && !i_rst;
    assign wb_busy = wb_valid_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else if (wb_load) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= addr_q;
            wb_data_q  <= wdata_q;
        end else if (drain) begin
            wb_valid_q <= 1'b0;
        end
    end
`else
    assign wb_load = 1'b0;
    assign drain   = 1'b0;
    assign wb_busy = 1'b0;
    assign wb_addr = addr_q;
    assign wb_data = wdata_q;
`endif

    assign cpu_issue = (state_q == S_PEND) && !i_vdu_read_en && !wb_busy && !i_rst;

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = addr_q;
        o_mem_wdata = wdata_q;
        if (i_vdu_read_en) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_vdu_read_addr;
        end else if (drain) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = wb_addr;
            o_mem_wdata = wb_data;
        end else if (cpu_issue) begin
            o_mem_en = 1'b1;
            o_mem_we = we_q;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_cpu_req) begin
                        we_q    <= i_cpu_we;
                        addr_q  <= i_cpu_addr;
                        wdata_q <= i_cpu_wdata;
                        state_q <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (cpu_issue) begin
                        state_q <= we_q ? S_ACK : S_RD_DATA;
                        ack_q   <= we_q;
                    end else if (wb_load) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    cpu_rdata_q <= i_mem_rdata;
                    ack_q       <= 1'b1;
                    state_q     <= S_ACK;
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The slot tracker keeps running through reset so a VDU read issued during reset still returns its data.
    always_ff @(posedge i_clk_sys) begin
        vdu_pend_q <= i_vdu_read_en;
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            vdu_data_q <= '0;
        end else if (vdu_pend_q) begin
            vdu_data_q <= i_mem_rdata;
        end
    end

    assign o_vdu_data  = vdu_pend_q ? i_mem_rdata : vdu_data_q;
    assign o_cpu_ack   = ack_q;
    assign o_cpu_rdata = cpu_rdata_q;

endmodule
